// File: rtl/i2c_req_arbiter.sv
// Round-robin share of one I2C master FSM between NUM_REQ requesters, one transaction at a time.
// gnt/m_en one cycle after req is sampled, done one cycle after m_done; held requests wait while busy.
module i2c_req_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                      i2c_clk_in,
  input  logic                      resetN,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_rw,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_nack,
  output logic                      rsp_timeout,
  output logic                      busy,
  output logic                      m_en,
  output logic                      m_rw,
  output logic [ADDR_W-1:0]         m_addr,
  output logic [DATA_W-1:0]         m_wdata,
  output logic                      m_abort,
  input  logic                      m_busy,
  input  logic                      m_done,
  input  logic                      m_nack,
  input  logic [DATA_W-1:0]         m_rdata
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
  // The abort fires on the edge where the counter would reach TIMEOUT_CYC.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, RESP} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx;
  logic [WD_W-1:0]  wdog;
  logic             win_vld;
  logic [IDX_W-1:0] win_idx;

  // Scan from farthest to nearest so the first requester after ptr ends up winning.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[IDX_W'((int'(ptr) + k) % NUM_REQ)]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge i2c_clk_in or negedge resetN) begin
    if (!resetN) begin
      state       <= IDLE;
      ptr         <= IDX_W'(NUM_REQ - 1);
      idx         <= '0;
      wdog        <= '0;
      gnt         <= '0;
      done        <= '0;
      rsp_rdata   <= '0;
      rsp_nack    <= 1'b0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
      m_en        <= 1'b0;
      m_rw        <= 1'b0;
      m_addr      <= '0;
      m_wdata     <= '0;
      m_abort     <= 1'b0;
    end else begin
      gnt     <= '0;
      done    <= '0;
      m_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            idx     <= win_idx;
            m_addr  <= req_addr[win_idx*ADDR_W +: ADDR_W];
            m_rw    <= req_rw[win_idx];
            m_wdata <= req_wdata[win_idx*DATA_W +: DATA_W];
            gnt     <= NUM_REQ'(1) << win_idx;
            m_en    <= 1'b1;
            busy    <= 1'b1;
            wdog    <= '0;
            state   <= LAUNCH;
          end
        end
        LAUNCH, WAIT_DONE: begin
          wdog <= wdog + 1'b1;
          // Completion beats the watchdog when both land on the same edge.
          if (m_done) begin
            m_en        <= 1'b0;
            done        <= NUM_REQ'(1) << idx;
            rsp_rdata   <= m_rw ? m_rdata : '0;
            rsp_nack    <= m_nack;
            rsp_timeout <= 1'b0;
            state       <= RESP;
          end else if (wdog == WD_LAST) begin
            m_en        <= 1'b0;
            m_abort     <= 1'b1;
            done        <= NUM_REQ'(1) << idx;
            rsp_rdata   <= '0;
            rsp_nack    <= 1'b0;
            rsp_timeout <= 1'b1;
            state       <= RESP;
          end else if (state == LAUNCH && m_busy) begin
            m_en  <= 1'b0;
            state <= WAIT_DONE;
          end
        end
        RESP: begin
          ptr         <= idx;
          rsp_rdata   <= '0;
          rsp_nack    <= 1'b0;
          rsp_timeout <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
